// File: rtl/mcu_spi.sv
// SPI mode-0 slave front end for the MCU link: synchronizes the asynchronous SPI pins,
// deserializes MOSI into bytes with a start qualifier and serializes the reply byte on MISO.
module mcu_spi #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       spi_io_ss,
    input  logic       spi_io_clk,
    input  logic       spi_io_din,
    output logic       spi_io_dout,
    output logic       data_in_strobe,
    output logic       data_in_start,
    output logic [7:0] data_in,
    input  logic [7:0] data_out
);

    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
    logic                   sck_dly_q, sck_dly_d;

    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] data_in_q, data_in_d;
    logic       first_q, first_d;
    logic       strobe_q, strobe_d;
    logic       start_q, start_d;

    logic ss_s, sck_s, din_s, sck_rise;

    always_comb begin
        ss_sync_d  = {ss_sync_q[SYNC_STAGES-2:0], spi_io_ss};
        sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], spi_io_clk};
        din_sync_d = {din_sync_q[SYNC_STAGES-2:0], spi_io_din};
        ss_s       = ss_sync_q[SYNC_STAGES-1];
        sck_s      = sck_sync_q[SYNC_STAGES-1];
        din_s      = din_sync_q[SYNC_STAGES-1];
        sck_dly_d  = sck_s;
        sck_rise   = sck_s & ~sck_dly_q;
    end

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        data_in_d = data_in_q;
        first_d   = first_q;
        strobe_d  = 1'b0;
        start_d   = 1'b0;
        if (ss_s) begin
            // Deselected: any partial byte is dropped and the next byte is a frame start.
            bit_cnt_d = 3'd0;
            rx_d      = 8'd0;
            first_d   = 1'b1;
        end else if (sck_rise) begin
            rx_d      = {rx_q[6:0], din_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd0) begin
                tx_d = data_out;
            end
            if (bit_cnt_q == 3'd7) begin
                data_in_d = {rx_q[6:0], din_s};
                strobe_d  = 1'b1;
                start_d   = first_q;
                first_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ss_sync_q  <= '0;
            sck_sync_q <= '0;
            din_sync_q <= '0;
            sck_dly_q  <= 1'b0;
            bit_cnt_q  <= 3'd0;
            rx_q       <= 8'd0;
            tx_q       <= 8'd0;
            data_in_q  <= 8'd0;
            first_q    <= 1'b1;
            strobe_q   <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            ss_sync_q  <= ss_sync_d;
            sck_sync_q <= sck_sync_d;
            din_sync_q <= din_sync_d;
            sck_dly_q  <= sck_dly_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            data_in_q  <= data_in_d;
            first_q    <= first_d;
            strobe_q   <= strobe_d;
            start_q    <= start_d;
        end
    end

    // Bit 0 of each byte comes straight from data_out because tx is only loaded on that rise.
    always_comb begin
        spi_io_dout = 1'b0;
        if (reset_n && !ss_s) begin
            if (bit_cnt_q == 3'd0) begin
                spi_io_dout = data_out[7];
            end else begin
                spi_io_dout = tx_q[3'd7 - bit_cnt_q];
            end
        end
    end

    assign data_in_strobe = strobe_q;
    assign data_in_start  = start_q;
    assign data_in        = data_in_q;

endmodule

// File: tb/tb_mcu_spi.sv
// Randomized bench for mcu_spi: drives mode-0 SPI frames into a 2-stage and a 3-stage
// instance and compares both against a bit-stream reference model.
module tb_mcu_spi;

    logic       clk;
    logic       reset_n;
    logic       spi_io_ss;
    logic       spi_io_clk;
    logic       spi_io_din;
    logic [7:0] data_out;

    logic       dout2, strobe2, start2;
    logic [7:0] data_in2;
    logic       dout3, strobe3, start3;
    logic [7:0] data_in3;

    mcu_spi #(.SYNC_STAGES(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .spi_io_ss(spi_io_ss), .spi_io_clk(spi_io_clk),
        .spi_io_din(spi_io_din), .spi_io_dout(dout2), .data_in_strobe(strobe2),
        .data_in_start(start2), .data_in(data_in2), .data_out(data_out)
    );

    mcu_spi #(.SYNC_STAGES(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .spi_io_ss(spi_io_ss), .spi_io_clk(spi_io_clk),
        .spi_io_din(spi_io_din), .spi_io_dout(dout3), .data_in_strobe(strobe3),
        .data_in_start(start3), .data_in(data_in3), .data_out(data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: the serial bit stream of the current frame, grouped into bytes.
    typedef struct {
        logic [7:0] d;
        logic       st;
        int         rc;
    } exp_t;

    exp_t       exp2[$];
    exp_t       exp3[$];
    logic [7:0] m_acc;
    int         m_nbits;
    logic       m_first;
    logic [7:0] m_reply;
    logic [7:0] miso2, miso3;
    int         ph;

    logic [7:0] dir_mosi[$];
    logic [7:0] dir_reply[$];
    logic [7:0] extra_byte;

    logic prev2 = 1'b0;
    logic prev3 = 1'b0;

    always @(negedge clk) begin : mon2
        exp_t e;
        if (reset_n) begin
            if (strobe2) begin
                check("strobe2_width", 32'(prev2), 32'd0);
                if (exp2.size() == 0) begin
                    check("strobe2_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp2.pop_front();
                    check("data_in2", 32'(data_in2), 32'(e.d));
                    check("start2", 32'(start2), 32'(e.st));
                    check("latency2", 32'(cyc - e.rc), 32'd3);
                end
            end else if (prev2) begin
                check("start2_low", 32'(start2), 32'd0);
            end
        end
        prev2 <= strobe2;
    end

    always @(negedge clk) begin : mon3
        exp_t e;
        if (reset_n) begin
            if (strobe3) begin
                check("strobe3_width", 32'(prev3), 32'd0);
                if (exp3.size() == 0) begin
                    check("strobe3_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp3.pop_front();
                    check("data_in3", 32'(data_in3), 32'(e.d));
                    check("start3", 32'(start3), 32'(e.st));
                    check("latency3", 32'(cyc - e.rc), 32'd4);
                end
            end else if (prev3) begin
                check("start3_low", 32'(start3), 32'd0);
            end
        end
        prev3 <= strobe3;
    end

    task automatic spi_bit(input logic b, input bit active);
        exp_t e;
        spi_io_din = b;
        repeat (ph) @(negedge clk);
        if (!active) begin
            check("dout2_idle", 32'(dout2), 32'd0);
            check("dout3_idle", 32'(dout3), 32'd0);
        end else begin
            miso2 = {miso2[6:0], dout2};
            miso3 = {miso3[6:0], dout3};
        end
        spi_io_clk = 1'b1;
        if (active) begin
            m_acc = {m_acc[6:0], b};
            m_nbits++;
            if (m_nbits == 8) begin
                e.d  = m_acc;
                e.st = m_first;
                e.rc = cyc;
                exp2.push_back(e);
                exp3.push_back(e);
                check("miso2", 32'(miso2), 32'(m_reply));
                check("miso3", 32'(miso3), 32'(m_reply));
                m_first = 1'b0;
                m_nbits = 0;
            end
        end
        repeat (ph) @(negedge clk);
        spi_io_clk = 1'b0;
    endtask

    task automatic frame(input int nbytes, input int nextra, input bit active, input bit directed);
        logic [7:0] mb;
        logic [7:0] rp;
        if (active) spi_io_ss = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbytes; i++) begin
            mb       = directed ? dir_mosi[i]  : 8'($urandom);
            rp       = directed ? dir_reply[i] : 8'($urandom);
            data_out = rp;
            m_reply  = rp;
            for (int j = 7; j >= 0; j--) spi_bit(mb[j], active);
        end
        for (int j = 0; j < nextra; j++) spi_bit(extra_byte[7-j], active);
        repeat (ph) @(negedge clk);
        spi_io_ss = 1'b1;
        m_first   = 1'b1;
        m_nbits   = 0;
        repeat (8) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_strobe2"}, 32'(strobe2), 32'd0);
        check({tag, "_start2"}, 32'(start2), 32'd0);
        check({tag, "_data_in2"}, 32'(data_in2), 32'd0);
        check({tag, "_dout2"}, 32'(dout2), 32'd0);
        check({tag, "_strobe3"}, 32'(strobe3), 32'd0);
        check({tag, "_start3"}, 32'(start3), 32'd0);
        check({tag, "_data_in3"}, 32'(data_in3), 32'd0);
        check({tag, "_dout3"}, 32'(dout3), 32'd0);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d cycles elapsed", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n    = 1'b0;
        spi_io_ss  = 1'b1;
        spi_io_clk = 1'b0;
        spi_io_din = 1'b0;
        data_out   = 8'hA7;
        m_acc      = 8'd0;
        m_nbits    = 0;
        m_first    = 1'b1;
        m_reply    = 8'd0;
        miso2      = 8'd0;
        miso3      = 8'd0;
        extra_byte = 8'd0;
        ph         = 8;

        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("por");
        end
        reset_n = 1'b1;
        repeat (6) @(negedge clk);

        // Two bytes in one frame with a constant reply byte.
        dir_mosi  = '{8'h04, 8'h52};
        dir_reply = '{8'h5C, 8'h5C};
        frame(2, 0, 1'b1, 1'b1);

        // Partial byte of ones, then a fresh frame.
        extra_byte = 8'hFF;
        frame(0, 5, 1'b1, 1'b1);
        dir_mosi  = '{8'hA5};
        dir_reply = '{8'h3C};
        frame(1, 0, 1'b1, 1'b1);

        // SS pulse with no clocks, then clocks with SS high.
        frame(0, 0, 1'b1, 1'b0);
        extra_byte = 8'h96;
        frame(2, 3, 1'b0, 1'b0);

        dir_mosi  = '{8'h3C};
        dir_reply = '{8'hC3};
        frame(1, 0, 1'b1, 1'b1);

        // Reset asserted mid-byte with SS held low.
        spi_io_ss = 1'b0;
        repeat (4) @(negedge clk);
        data_out = 8'hFF;
        for (int j = 0; j < 3; j++) spi_bit(1'b1, 1'b1);
        reset_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("midrst");
        end
        reset_n = 1'b1;
        m_nbits = 0;
        m_first = 1'b1;
        for (int j = 0; j < 5; j++) spi_bit(1'b0, 1'b1);
        repeat (ph) @(negedge clk);
        spi_io_ss = 1'b1;
        m_first   = 1'b1;
        m_nbits   = 0;
        repeat (8) @(negedge clk);

        for (int f = 0; f < 20; f++) begin
            ph         = $urandom_range(4, 8);
            extra_byte = 8'($urandom);
            frame($urandom_range(0, 4),
                  ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0,
                  ($urandom_range(0, 5) != 0), 1'b0);
        end

        repeat (20) @(negedge clk);
        check("exp2_pending", 32'(exp2.size()), 32'd0);
        check("exp3_pending", 32'(exp3.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
